// File: rtl/priority_encoder_pkg.sv
// Shared types and widths for the clocked priority encoder.
// Imported by both the combinational core and the registered top.
package priority_encoder_pkg;
  localparam int PE_WIDTH = 8;
  localparam int PE_OUT_W = $clog2(PE_WIDTH);

  typedef logic [PE_WIDTH-1:0] pe_req_t;
  typedef logic [PE_OUT_W-1:0] pe_idx_t;
endpackage

// File: rtl/priority_encoder_core.sv
// Combinational binary-tree priority encoder.
// The upper half wins at each level when it has any request set.
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] oh
);

  localparam int NODES = 2 * WIDTH - 1;
  localparam int LEAF0 = WIDTH - 1;

  // Heap layout: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  logic             tany [NODES];
  logic [OUT_W-1:0] tidx [NODES];

  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    assign tany[LEAF0+i] = in[i];
    assign tidx[LEAF0+i] = '0;
  end

  for (genvar n = 0; n < LEAF0; n++) begin : g_node
    localparam int DEPTH = $clog2(n + 2) - 1;
    localparam int HGT   = OUT_W - DEPTH;
    localparam logic [OUT_W-1:0] HBIT = OUT_W'(1) << (HGT - 1);

    assign tany[n] = tany[2*n+1] | tany[2*n+2];
    assign tidx[n] = tany[2*n+2] ? (HBIT | tidx[2*n+2])
                                 : tidx[2*n+1];
  end

  assign any = tany[0];
  assign idx = tidx[0];
  assign oh  = any ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/priority_encoder.sv
// Registered 8-to-3 priority encoder with enable, valid and one-hot grant.
// Results appear one cycle after sampling; disable or no request yields zeros.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  logic [OUT_W-1:0] idx;
  logic             any;
  logic [WIDTH-1:0] oh;

  priority_encoder_core #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) u_core (
    .in (in),
    .idx(idx),
    .any(any),
    .oh (oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      valid  <= 1'b0;
      onehot <= '0;
    end else if (en && any) begin
      out    <= idx;
      valid  <= 1'b1;
      onehot <= oh;
    end else begin
      out    <= '0;
      valid  <= 1'b0;
      onehot <= '0;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and exhaustive bench for priority_encoder.
// Inputs change #1 after posedge; outputs are checked at that same point.
module tb_priority_encoder;
  import priority_encoder_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    en;
  pe_req_t in;
  pe_idx_t out;
  logic    valid;
  pe_req_t onehot;

  int n_run  = 0;
  int n_fail = 0;

  priority_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid),
    .onehot(onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [31:0] eo,
                      input logic [31:0] ev, input logic [31:0] eh);
    chk({tag, ".out"}, 32'(out), eo);
    chk({tag, ".valid"}, 32'(valid), ev);
    chk({tag, ".onehot"}, 32'(onehot), eh);
  endtask

  typedef struct {
    logic [7:0] v;
    logic [2:0] o;
    logic       vl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b00000000, 3'd0, 1'b0};
    vecs[1] = '{8'b00001001, 3'd3, 1'b1};
    vecs[2] = '{8'b00000001, 3'd0, 1'b1};
    vecs[3] = '{8'b01100110, 3'd6, 1'b1};
    vecs[4] = '{8'b00010010, 3'd4, 1'b1};
    vecs[5] = '{8'b00000011, 3'd1, 1'b1};
    vecs[6] = '{8'b00110011, 3'd5, 1'b1};
    vecs[7] = '{8'b00000100, 3'd2, 1'b1};

    rst = 1'b1;
    en  = 1'b1;
    in  = 8'hFF;
    step();
    step();
    chk3("reset_hold", 0, 0, 0);
    rst = 1'b0;
    step();
    chk3("after_reset", 7, 1, 8'h80);

    for (int i = 0; i < 8; i++) begin
      in = vecs[i].v;
      step();
      chk3($sformatf("vec%0d", i), 32'(vecs[i].o), 32'(vecs[i].vl),
           vecs[i].vl ? (32'd1 << vecs[i].o) : 32'd0);
    end

    in = 8'b01100110;
    en = 1'b0;
    step();
    chk3("en_low", 0, 0, 0);
    en = 1'b1;
    step();
    chk3("en_high", 6, 1, 8'h40);

    in = 8'h80;
    step();
    chk3("b2b_0", 7, 1, 8'h80);
    in = 8'h01;
    step();
    chk3("b2b_1", 0, 1, 8'h01);

    in = 8'b00110011;
    step();
    chk3("pre_rst", 5, 1, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    chk3("async_rst", 0, 0, 0);
    #1;
    rst = 1'b0;
    step();
    chk3("post_rst", 5, 1, 8'h20);

    for (int v = 0; v < 256; v++) begin
      logic [2:0] eo;
      logic       ev;
      eo = '0;
      ev = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        if (!ev && v[b]) begin
          eo = 3'(b);
          ev = 1'b1;
        end
      end
      in = 8'(v);
      step();
      chk3($sformatf("sweep%0d", v), 32'(eo), 32'(ev),
           ev ? (32'd1 << eo) : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
